// File: rtl/io_bus_ctrl.sv
// CPU byte-bus splitter between the 128 KB RAM and the I/O window at 0x3xxxx.
// Owns the UART RX/TX FIFOs, the free-running cycle counter and the stop flag.
module io_bus_ctrl #(
    parameter int RX_DEPTH = 16,
    parameter int TX_DEPTH = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] cpu_a_in,
    input  logic        cpu_wr_in,
    input  logic [7:0]  cpu_dout_in,
    output logic [7:0]  cpu_din_out,
    output logic        rdy_out,
    output logic [16:0] ram_a_out,
    output logic        ram_wr_out,
    output logic [7:0]  ram_dout_out,
    input  logic [7:0]  ram_din_in,
    input  logic        rx_valid_in,
    input  logic [7:0]  rx_data_in,
    output logic        rx_ready_out,
    output logic        tx_valid_out,
    output logic [7:0]  tx_data_out,
    input  logic        tx_ready_in,
    output logic        prog_done_out
);
    localparam int RXW = $clog2(RX_DEPTH);
    localparam int TXW = $clog2(TX_DEPTH);
    localparam logic [RXW:0]   RX_FULL = (RXW + 1)'(RX_DEPTH);
    localparam logic [TXW:0]   TX_FULL = (TXW + 1)'(TX_DEPTH);
    localparam logic [RXW-1:0] RX_STEP = RXW'(1);
    localparam logic [TXW-1:0] TX_STEP = TXW'(1);

    logic [7:0]     rxMem_r [RX_DEPTH];
    logic [RXW-1:0] rxWr_r;
    logic [RXW-1:0] rxRd_r;
    logic [RXW:0]   rxCnt_r;
    logic [7:0]     txMem_r [TX_DEPTH];
    logic [TXW-1:0] txWr_r;
    logic [TXW-1:0] txRd_r;
    logic [TXW:0]   txCnt_r;
    logic [31:0]    cycleCnt_r;
    logic [31:0]    snap_r;
    logic           rdIo_r;
    logic [7:0]     rdByte_r;
    logic           done_r;

    logic           isIo_s;
    logic [15:0]    ioOff_s;
    logic           txFull_s;
    logic           txPushNeed_s;
    logic           txPush_s;
    logic [7:0]     txPushData_s;
    logic           txPop_s;
    logic           rxPush_s;
    logic           rxPop_s;
    logic           rdAcc_s;
    logic           rdy_s;
    logic [7:0]     rxHead_s;
    logic [7:0]     ioByte_s;
    logic           unusedAddr_s;

    assign isIo_s       = (cpu_a_in[17:16] == 2'b11);
    assign ioOff_s      = cpu_a_in[15:0];
    assign unusedAddr_s = ^cpu_a_in[31:18];

    assign ram_a_out    = cpu_a_in[16:0];
    assign ram_dout_out = cpu_dout_in;
    assign ram_wr_out   = cpu_wr_in & ~isIo_s;

    // Full is taken from the registered count so a same-cycle pop never releases a stall
    assign txFull_s     = (txCnt_r == TX_FULL);
    assign txPushNeed_s = isIo_s & cpu_wr_in &
                          (((ioOff_s == 16'h0000) & (cpu_dout_in != 8'h00)) |
                           (ioOff_s == 16'h0004));
    assign rdy_s        = ~(txPushNeed_s & txFull_s);
    assign txPush_s     = txPushNeed_s & ~txFull_s;
    assign txPushData_s = (ioOff_s == 16'h0000) ? cpu_dout_in : 8'h00;
    assign txPop_s      = (txCnt_r != {(TXW + 1){1'b0}}) & tx_ready_in;

    assign rdAcc_s      = rdy_s & ~cpu_wr_in;
    assign rxPush_s     = rx_valid_in & (rxCnt_r != RX_FULL);
    assign rxPop_s      = rdAcc_s & isIo_s & (ioOff_s == 16'h0000) &
                          (rxCnt_r != {(RXW + 1){1'b0}});

    assign rdy_out       = rdy_s;
    assign rx_ready_out  = (rxCnt_r != RX_FULL);
    assign tx_valid_out  = (txCnt_r != {(TXW + 1){1'b0}});
    assign tx_data_out   = txMem_r[txRd_r];
    assign prog_done_out = done_r;

    // RX head byte, zero when the FIFO is empty
    always_comb begin
        rxHead_s = 8'h00;
        if (rxCnt_r != {(RXW + 1){1'b0}}) begin
            rxHead_s = rxMem_r[rxRd_r];
        end else begin
            rxHead_s = 8'h00;
        end
    end

    // IO read byte selection
    always_comb begin
        ioByte_s = 8'h00;
        case (ioOff_s)
            16'h0000: ioByte_s = rxHead_s;
            16'h0004: ioByte_s = cycleCnt_r[7:0];
            16'h0005: ioByte_s = snap_r[15:8];
            16'h0006: ioByte_s = snap_r[23:16];
            16'h0007: ioByte_s = snap_r[31:24];
            default:  ioByte_s = 8'h00;
        endcase
    end

    // Read return mux: RAM data arrives with one cycle of latency, IO byte was registered
    always_comb begin
        cpu_din_out = 8'h00;
        if (rdIo_r) begin
            cpu_din_out = rdByte_r;
        end else begin
            cpu_din_out = ram_din_in;
        end
    end

    // Read source/byte capture; reset selects the IO path so the bus reads 0x00
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rdIo_r   <= 1'b1;
            rdByte_r <= 8'h00;
        end else if (rdAcc_s) begin
            rdIo_r   <= isIo_s;
            rdByte_r <= ioByte_s;
        end
    end

    // Free-running cycle counter and read-triggered snapshot
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cycleCnt_r <= 32'h0000_0000;
            snap_r     <= 32'h0000_0000;
        end else begin
            cycleCnt_r <= cycleCnt_r + 32'd1;
            if (rdAcc_s && isIo_s && (ioOff_s == 16'h0004)) begin
                snap_r <= cycleCnt_r;
            end
        end
    end

    // Sticky program-stop flag
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            done_r <= 1'b0;
        end else if (rdy_s && isIo_s && cpu_wr_in && (ioOff_s == 16'h0004)) begin
            done_r <= 1'b1;
        end
    end

    // RX FIFO pointers and occupancy
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rxWr_r  <= {RXW{1'b0}};
            rxRd_r  <= {RXW{1'b0}};
            rxCnt_r <= {(RXW + 1){1'b0}};
        end else begin
            if (rxPush_s) begin
                rxWr_r <= rxWr_r + RX_STEP;
            end
            if (rxPop_s) begin
                rxRd_r <= rxRd_r + RX_STEP;
            end
            rxCnt_r <= rxCnt_r + {{RXW{1'b0}}, rxPush_s} - {{RXW{1'b0}}, rxPop_s};
        end
    end

    // TX FIFO pointers and occupancy
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            txWr_r  <= {TXW{1'b0}};
            txRd_r  <= {TXW{1'b0}};
            txCnt_r <= {(TXW + 1){1'b0}};
        end else begin
            if (txPush_s) begin
                txWr_r <= txWr_r + TX_STEP;
            end
            if (txPop_s) begin
                txRd_r <= txRd_r + TX_STEP;
            end
            txCnt_r <= txCnt_r + {{TXW{1'b0}}, txPush_s} - {{TXW{1'b0}}, txPop_s};
        end
    end

    // FIFO storage; contents are qualified by the counts so no reset is needed
    always_ff @(posedge clk_in) begin
        if (rxPush_s) begin
            rxMem_r[rxWr_r] <= rx_data_in;
        end
        if (txPush_s) begin
            txMem_r[txWr_r] <= txPushData_s;
        end
    end

endmodule

// File: doc/io_bus_ctrl.md
Name: io_bus_ctrl

Overview:
- Sits directly downstream of the CPU core's byte-wide memory bus (address, write strobe, data in/out) and splits traffic between the 128 KB RAM and the memory-mapped I/O window at mem_a[17:16]==2'b11.
- Owns the UART RX/TX byte FIFOs, the free-running cycle counter and the program-stop flag.
- Generates the CPU ready signal, which pauses the core while a TX write cannot be accepted.

Parameters:
- RX_DEPTH, 16, RX FIFO entries (power of two, >=2).
- TX_DEPTH, 16, TX FIFO entries (power of two, >=2).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset; asynchronous, active-low
- cpu_a_in  input  32  CPU address; only [17:0] decoded
- cpu_wr_in  input  1  1 = write, 0 = read
- cpu_dout_in  input  8  write data from CPU
- cpu_din_out  output  8  read data to CPU, valid the cycle after the request
- rdy_out  output  1  CPU ready; low pauses the CPU
- ram_a_out  output  17  RAM address
- ram_wr_out  output  1  RAM write enable
- ram_dout_out  output  8  RAM write data
- ram_din_in  input  8  RAM read data (1-cycle latency)
- rx_valid_in  input  1  UART RX byte available
- rx_data_in  input  8  UART RX byte
- rx_ready_out  output  1  RX FIFO can accept a byte
- tx_valid_out  output  1  TX FIFO non-empty
- tx_data_out  output  8  TX FIFO head byte
- tx_ready_in  input  1  UART TX consumes head when high with tx_valid_out
- prog_done_out  output  1  sticky program-stop flag

Behaviour:
- Decode: io = (cpu_a_in[17:16]==2'b11). A request is accepted in a cycle only when rdy_out=1.
- RAM path, combinational:
  - ram_a_out = cpu_a_in[16:0]; ram_dout_out = cpu_dout_in.
  - ram_wr_out = cpu_wr_in & ~io.
- Read return: on an accepted read, register the source select (RAM/IO) and the IO byte. Next cycle cpu_din_out = ram_din_in if RAM, else the registered IO byte. This matches the 2-cycle read contract.
- IO reads:
  - 0x30000: if RX FIFO non-empty, pop the head and return it; if empty, return 0x00 and do not pop.
  - 0x30004: latch the 32-bit cycle counter into a snapshot register and return byte 0. 0x30005–0x30007 return snapshot bytes 1–3, little-endian, without re-latching.
  - Any other IO address returns 0x00.
- IO writes:
  - 0x30000 with data != 0x00: push to the TX FIFO. Data 0x00 is ignored (no push, never stalls).
  - 0x30004: set prog_done_out (sticky until reset) and push 0x00 to the TX FIFO.
  - Any other IO address: ignored.
- Stall: rdy_out = ~(io & cpu_wr_in & tx_push_needed & tx_full).
  - tx_full is computed from the registered count, so a same-cycle pop does not unstall.
  - The write is accepted in the first cycle tx_full=0.
- FIFOs (both): circular buffer; read/write pointers wrap modulo depth; count register 0..DEPTH.
  - Simultaneous push and pop on a non-empty, non-full FIFO leaves count unchanged.
  - Pop on empty is a no-op.
  - RX: push when rx_valid_in & rx_ready_out; rx_ready_out = (count != RX_DEPTH).
  - TX: pop when tx_valid_out & tx_ready_in; tx_data_out = head entry.
- Cycle counter: 32 bits, +1 every clock while out of reset, wraps 0xFFFFFFFF -> 0. Runs independently of rdy_out.
- Reset (rst_in low, async):
  - FIFOs empty; counter, snapshot and read registers cleared.
  - cpu_din_out = 0x00, rdy_out = 1, tx_valid_out = 0, rx_ready_out = 1, prog_done_out = 0.
  - An in-flight read is discarded.
- Latency:
  - RX byte is readable by the CPU the cycle after it is pushed.
  - TX byte appears on tx_data_out the cycle after the write is accepted.

Test Plan:
- RAM: write 0xA5 to 0x00100, then read 0x00100 -> ram_wr_out=1 only in the write cycle; cpu_din_out=0xA5 one cycle after the read request.
- RX: inject 0x41 then 0x42, read 0x30000 three times -> returns 0x41, 0x42, 0x00; count ends at 0.
- TX backpressure: hold tx_ready_in=0, write 17 nonzero bytes to 0x30000 -> rdy_out=0 on the 17th write. Raise tx_ready_in for one cycle -> rdy_out stays 0 that cycle and returns to 1 the next; the 17th byte is accepted and tx_data_out order is preserved.
- Zero write: write 0x00 to 0x30000 -> no TX push, rdy_out=1 even with TX full.
- Counter: read 0x30004..0x30007 at counter 0x000001FF, with 3 cycles elapsing between reads -> bytes FF,01,00,00 (coherent snapshot). Force counter 0xFFFFFFFF -> next value 0.
- Stop plus reset: write 0x30004 -> prog_done_out=1 and 0x00 enqueued to TX. Assert rst_in low mid-read -> all outputs at reset values immediately, FIFOs empty.
